// File: rtl/fetch_sequencer_if.sv
// Instruction-fetch sequencer bus: instruction-memory port, decoder/datapath
// handshake and status. master = sequencer side, slave = memory/decoder side.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;
    logic [15:0]       instr;
    logic [3:0]        OpCode;
    logic              instr_valid;
    logic              exec_done;
    logic              Halt;
    logic [1:0]        Branch;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic [15:0]       retired;

    modport master (
        output imem_req, imem_addr, instr, OpCode, instr_valid, pc, halted, retired,
        input  imem_ack, imem_rdata, exec_done, Halt, Branch, taken, target
    );

    modport slave (
        input  imem_req, imem_addr, instr, OpCode, instr_valid, pc, halted, retired,
        output imem_ack, imem_rdata, exec_done, Halt, Branch, taken, target
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch and sequencing unit: holds the PC, fetches one 16-bit
// instruction per request/ack, issues it to the decoder and applies the
// decoder's Halt/Branch result once the datapath reports completion.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | just out of reset, one cycle before the first fetch
// FETCH   | imem_req high at pc, waiting for imem_ack
// ISSUE   | instr_valid pulse, instruction presented to the decoder
// EXEC    | waiting for exec_done, then choose next pc
// HALTED  | stopped; only reset leaves this state
module fetch_sequencer #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst,
    fetch_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        ISSUE  = 3'd2,
        EXEC   = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       instr_q;
    logic [15:0]       retired_q;
    logic              req_q;
    logic              valid_q;
    logic              halted_q;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target_even;
    logic [15:0]       retired_inc;

    // Next-PC candidates and saturating retire count.
    always_comb begin
        pc_inc      = pc_q + ADDR_W'(2);
        target_even = bus.target & ~{{(ADDR_W-1){1'b0}}, 1'b1};
        retired_inc = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            retired_q <= '0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    valid_q <= 1'b0;
                    state   <= EXEC;
                end
                EXEC: begin
                    if (bus.exec_done) begin
                        retired_q <= retired_inc;
                        if (bus.Halt) begin
                            halted_q <= 1'b1;
                            state    <= HALTED;
                        end else begin
                            case (bus.Branch)
                                2'b00:   pc_q <= bus.taken ? target_even : pc_inc;
                                2'b10:   pc_q <= target_even;
                                default: pc_q <= pc_inc;
                            endcase
                            req_q <= 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    req_q    <= 1'b0;
                    halted_q <= 1'b1;
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.OpCode      = instr_q[15:12];
    assign bus.instr_valid = valid_q;
    assign bus.halted      = halted_q;
    assign bus.retired     = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random
// instruction streams checked against a transaction-level PC/retire model.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // reference model state (one update per completed instruction)
    logic [15:0] m_pc;
    logic [15:0] m_ret;
    logic        m_halt;

    fetch_sequencer_if #(.ADDR_W(16)) bus ();

    fetch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.exec_done  = 1'b0;
        bus.Halt       = 1'b0;
        bus.Branch     = 2'b01;
        bus.taken      = 1'b0;
        bus.target     = 16'h0000;
    endtask

    task automatic model_reset();
        m_pc   = 16'h0000;
        m_ret  = 16'h0000;
        m_halt = 1'b0;
    endtask

    // Next-PC / retire rules applied to one finished instruction.
    task automatic model_retire(input logic h, input logic [1:0] br, input logic tk,
                                input logic [15:0] tg);
        if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
        if (h)
            m_halt = 1'b1;
        else if (br == 2'b10 || (br == 2'b00 && tk))
            m_pc = {tg[15:1], 1'b0};
        else
            m_pc = m_pc + 16'd2;
    endtask

    // One complete instruction: fetch with aw wait cycles, exec with ew wait cycles.
    task automatic run_instr(input int aw, input int ew, input logic [15:0] word,
                             input logic h, input logic [1:0] br, input logic tk,
                             input logic [15:0] tg);
        int n;
        int t0;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 10) begin
            nxt();
            n++;
        end
        chk("req_rise", {31'd0, bus.imem_req}, 32'd1);
        chk("fetch_addr", {16'd0, bus.imem_addr}, {16'd0, m_pc});
        t0 = cyc;
        repeat (aw) begin
            nxt();
            chk("wait_addr_stable", {16'd0, bus.imem_addr}, {16'd0, m_pc});
            chk("wait_req_held", {31'd0, bus.imem_req}, 32'd1);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        nxt();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'($urandom);
        // decoder-side noise during ISSUE must be ignored
        bus.exec_done  = 1'($urandom);
        bus.Halt       = 1'b1;
        bus.Branch     = 2'b10;
        bus.target     = 16'h5554;
        chk("issue_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("issue_instr", {16'd0, bus.instr}, {16'd0, word});
        chk("issue_opcode", {28'd0, bus.OpCode}, {28'd0, word[15:12]});
        chk("issue_req_low", {31'd0, bus.imem_req}, 32'd0);
        nxt();
        bus.exec_done = 1'b0;
        bus.Halt      = 1'b0;
        chk("exec_valid_low", {31'd0, bus.instr_valid}, 32'd0);
        repeat (ew) begin
            bus.imem_ack = 1'($urandom);
            nxt();
        end
        bus.imem_ack  = 1'b0;
        bus.exec_done = 1'b1;
        bus.Halt      = h;
        bus.Branch    = br;
        bus.taken     = tk;
        bus.target    = tg;
        nxt();
        clear_inputs();
        model_retire(h, br, tk, tg);
        chk("period", 32'(cyc - t0), 32'(3 + aw + ew));
        chk("pc", {16'd0, bus.pc}, {16'd0, m_pc});
        chk("retired", {16'd0, bus.retired}, {16'd0, m_ret});
        chk("halted", {31'd0, bus.halted}, {31'd0, m_halt});
        chk("opcode_stable", {28'd0, bus.OpCode}, {28'd0, word[15:12]});
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        nxt();
        nxt();
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_pc", {16'd0, bus.pc}, 32'd0);
        chk("rst_retired", {16'd0, bus.retired}, 32'd0);
        chk("rst_instr", {16'd0, bus.instr}, 32'd0);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        #1;
        nxt();
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, bus.halted}, 32'd0);
        chk("rst_addr", {16'd0, bus.imem_addr}, 32'd0);
        chk("rst_opcode", {28'd0, bus.OpCode}, 32'd0);
        do_reset();
        nxt();
        chk("first_req", {31'd0, bus.imem_req}, 32'd1);

        // sequential run: 0,2,4,6 at 3 cycles each
        for (int i = 0; i < 4; i++)
            run_instr(0, 0, 16'($urandom), 1'b0, 2'b01, 1'($urandom), 16'($urandom));
        chk("seq_retired4", {16'd0, bus.retired}, 32'd4);
        chk("seq_next_addr", {16'd0, bus.imem_addr}, 32'h0008);

        // conditional branch at 0x0010, taken then not taken
        run_instr(0, 0, 16'h1234, 1'b0, 2'b10, 1'b0, 16'h0011);
        run_instr(0, 0, 16'h2000, 1'b0, 2'b00, 1'b1, 16'h0041);
        chk("br_taken_addr", {16'd0, bus.imem_addr}, 32'h0040);
        run_instr(0, 0, 16'h3000, 1'b0, 2'b10, 1'b0, 16'h0010);
        run_instr(0, 0, 16'h2000, 1'b0, 2'b00, 1'b0, 16'h0041);
        chk("br_not_taken_addr", {16'd0, bus.imem_addr}, 32'h0012);

        // wait states: 3 ack waits + 2 exec waits = 8-cycle period
        run_instr(3, 2, 16'hA5A5, 1'b0, 2'b11, 1'b1, 16'h0100);

        // wrap at top of address space
        run_instr(0, 0, 16'h4000, 1'b0, 2'b10, 1'b0, 16'hFFFF);
        chk("wrap_pre", {16'd0, bus.imem_addr}, 32'hFFFE);
        run_instr(0, 0, 16'h5000, 1'b0, 2'b01, 1'b0, 16'h1234);
        chk("wrap_addr", {16'd0, bus.imem_addr}, 32'h0000);

        // random instruction stream
        for (int i = 0; i < 30; i++)
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      16'($urandom), 1'b0, 2'($urandom), 1'($urandom), 16'($urandom));

        // halt priority at 0x0008
        run_instr(0, 0, 16'hF000, 1'b0, 2'b10, 1'b0, 16'h0008);
        begin
            logic [15:0] ret_before;
            ret_before = bus.retired;
            run_instr(1, 1, 16'hF001, 1'b1, 2'b10, 1'b1, 16'h0200);
            chk("halt_retired_once", {16'd0, bus.retired}, {16'd0, ret_before + 16'd1});
        end
        for (int i = 0; i < 20; i++) begin
            bus.imem_ack  = 1'($urandom);
            bus.exec_done = 1'($urandom);
            bus.Branch    = 2'($urandom);
            bus.taken     = 1'($urandom);
            nxt();
            chk("halt_req_low", {31'd0, bus.imem_req}, 32'd0);
            chk("halt_flag", {31'd0, bus.halted}, 32'd1);
            chk("halt_pc", {16'd0, bus.pc}, 32'h0008);
        end

        // reset mid-fetch with ack arriving during reset
        do_reset();
        run_instr(0, 0, 16'h7777, 1'b0, 2'b01, 1'b0, 16'h0000);
        nxt();
        chk("mid_req_high", {31'd0, bus.imem_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_req_async_drop", {31'd0, bus.imem_req}, 32'd0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 16'hBEEF;
        nxt();
        nxt();
        chk("mid_rst_instr", {16'd0, bus.instr}, 32'd0);
        chk("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #1;
        chk("mid_release_req", {31'd0, bus.imem_req}, 32'd0);
        nxt();
        chk("mid_refetch_req", {31'd0, bus.imem_req}, 32'd1);
        chk("mid_refetch_addr", {16'd0, bus.imem_addr}, 32'h0000);
        for (int i = 0; i < 5; i++)
            run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      16'($urandom), 1'b0, 2'($urandom), 1'($urandom), 16'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // hard stop in case a wait never resolves
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and sequencing unit for the 16-bit datapath. It holds the program counter and fetches 16-bit instructions over a request/acknowledge instruction-memory port. It presents each instruction and its 4-bit opcode to the control decoder, then waits for the datapath to finish. It applies the decoder's `Halt`/`Branch` result to choose the next PC. It is the producer of `OpCode` and the consumer of `Halt` and `Branch`.

## Interface
- `ADDR_W`, 16, PC / instruction-memory address width
- `RESET_PC`, 16'h0000, PC value loaded at reset; bit 0 must be 0
- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous, active-low; one clock domain only
- `imem_req`  out  1  instruction-memory read request
- `imem_addr`  out  ADDR_W  fetch address, always equal to current PC
- `imem_ack`  in  1  read complete; `imem_rdata` valid in the same cycle
- `imem_rdata`  in  16  instruction word
- `instr`  out  16  instruction register
- `OpCode`  out  4  `instr[15:12]`, to control decoder
- `instr_valid`  out  1  one-cycle pulse: new instruction issued
- `exec_done`  in  1  datapath has finished the issued instruction
- `Halt`  in  1  from decoder; sampled with `exec_done`
- `Branch`  in  2  from decoder; sampled with `exec_done`
- `taken`  in  1  branch condition result (ALU compare; jump drives 1)
- `target`  in  ADDR_W  redirect address
- `pc`  out  ADDR_W  current PC
- `halted`  out  1  sequencer stopped
- `retired`  out  16  count of completed instructions, saturating

## Operation
- States: IDLE, FETCH, ISSUE, EXEC, HALTED.
- Reset (rst=0, async) values:
  - state IDLE; `pc`=`RESET_PC`, `instr`=0, `retired`=0.
  - `imem_req`=0, `instr_valid`=0, `halted`=0.
  - `imem_addr`=`RESET_PC`, `OpCode`=0.
- IDLE: go to FETCH on the next edge after reset release.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_ack`.
  - On `imem_ack`, `instr`<=`imem_rdata`; go to ISSUE.
- ISSUE: `instr_valid`=1 for exactly this cycle; go to EXEC.
- EXEC: wait for `exec_done`. On `exec_done`:
  - `Halt`=1: go to HALTED; `pc` unchanged; `retired` increments.
  - Else `Branch`=2'b01 or 2'b11: `pc`<=`pc`+2.
  - Else `Branch`=2'b00: `pc`<=`taken` ? {`target`[ADDR_W-1:1],1'b0} : `pc`+2.
  - Else `Branch`=2'b10: `pc`<={`target`[ADDR_W-1:1],1'b0} unconditionally.
  - Non-halt cases: `retired` increments; go to FETCH.
- HALTED:
  - `halted`=1, `imem_req`=0; all inputs ignored.
  - Exit only by reset.
- Arithmetic and width rules:
  - `pc`+2 wraps modulo 2^ADDR_W (16'hFFFE → 16'h0000).
  - `retired` saturates at 16'hFFFF.
- `Halt` has priority over any `Branch` value in the same `exec_done` cycle.
- Ignored inputs:
  - `imem_ack` outside FETCH.
  - `exec_done` outside EXEC.
- `OpCode` and `instr` stay stable from ISSUE until the next fetch captures new data.

## Timing
- Outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- `imem_req` rises on the first edge after reset release + 1 (IDLE→FETCH).
- Zero-wait memory (ack in the first FETCH cycle) with `exec_done` in the first EXEC cycle gives 3 cycles per instruction: FETCH, ISSUE, EXEC.
- Each wait cycle on `imem_ack` or `exec_done` adds exactly one cycle.
- Reset asserted mid-FETCH: `imem_req` drops immediately (asynchronously); any in-flight ack after that is ignored.
- Reset asserted mid-EXEC: no PC update and no `retired` increment occur.

## Test plan
- Sequential run:
  - Stimulus: `RESET_PC`=0; zero-wait memory with `Branch`=01, `Halt`=0.
  - Required: `imem_addr` sequence 0,2,4,6; `instr_valid` every 3rd cycle; `retired`=4 after 4 instructions.
- Conditional branch:
  - Stimulus: at pc=16'h0010, `Branch`=00, `target`=16'h0041, first with `taken`=1, then repeated at 16'h0010 with `taken`=0.
  - Required: next `imem_addr` is 16'h0040 when taken, 16'h0012 when not taken.
- Halt priority:
  - Stimulus: at pc=16'h0008, `exec_done` with `Halt`=1 and `Branch`=10.
  - Required: `halted`=1, `pc` stays 16'h0008, `imem_req` stays 0 for 20 cycles, `retired` increments once.
- Wait states:
  - Stimulus: `imem_ack` delayed 3 cycles; `exec_done` delayed 2 cycles.
  - Required: `imem_addr` stable throughout the wait; instruction period is 8 cycles.
- Wrap:
  - Stimulus: pc=16'hFFFE with `Branch`=01.
  - Required: next fetch at 16'h0000.
- Reset mid-fetch:
  - Stimulus: `rst`=0 while `imem_req`=1, then `imem_ack` pulses during reset; release `rst`.
  - Required: `imem_req`=0 during reset and `instr` stays 0; first fetch after release is at `RESET_PC` one cycle later.
